// File: rtl/icache_2way_refill.sv
// icache_2way_refill: 2-way set-associative instruction cache with multi-word
// lines, LRU replacement, whole-cache flush and an abortable refill FSM.
// Optional build macro: ICACHE_PERF_COUNTERS_EN adds perf_hits / perf_misses.
module icache_2way_refill #(
    parameter int SET_BITS  = 4,
    parameter int LINE_BITS = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_addr,
    output logic        fetch_hit,
    output logic [31:0] fetch_data,
    input  logic        flush,
    output logic        busy,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_data
`ifdef ICACHE_PERF_COUNTERS_EN
    ,
    output logic [31:0] perf_hits,
    output logic [31:0] perf_misses
`endif
);
    localparam int TAG_W = 30 - SET_BITS - LINE_BITS;
    localparam int SETS  = 1 << SET_BITS;
    localparam int WORDS = 1 << LINE_BITS;
    localparam int OFF   = 2 + LINE_BITS;

    typedef enum logic [1:0] {IDLE, REQ, FILL_DONE} state_t;

    state_t                    state_q;
    logic [1:0][SETS-1:0]      valid_q;
    logic [SETS-1:0]           lru_q;      // 0: way0 is least recently used
    logic [TAG_W-1:0]          tag_q  [2][SETS];
    logic [31:0]               data_q [2][SETS][WORDS];
    logic [TAG_W-1:0]          base_tag_q;
    logic [SET_BITS-1:0]       base_set_q;
    logic                      victim_q;
    logic [LINE_BITS-1:0]      cnt_q;
    logic                      mem_req_q;
    logic [31:0]               mem_addr_q;

    logic [TAG_W-1:0]          f_tag;
    logic [SET_BITS-1:0]       f_set;
    logic [LINE_BITS-1:0]      f_word;
    logic                      match0, match1, miss, vic;
    logic [LINE_BITS-1:0]      cnt_nxt;

    // Byte offset bits never affect a word fetch.
    logic unused_addr_bits;
    assign unused_addr_bits = ^fetch_addr[1:0];

    // Tag compare, hit/miss decode and victim choice for the incoming fetch.
    always_comb begin
        f_tag     = fetch_addr[31:OFF+SET_BITS];
        f_set     = fetch_addr[OFF+SET_BITS-1:OFF];
        f_word    = fetch_addr[OFF-1:2];
        match0    = valid_q[0][f_set] && (tag_q[0][f_set] == f_tag);
        match1    = valid_q[1][f_set] && (tag_q[1][f_set] == f_tag);
        fetch_hit = fetch_valid && (state_q == IDLE) && (match0 || match1);
        miss      = fetch_valid && (state_q == IDLE) && !(match0 || match1);
        // way0 wins if both ways match (only reachable from a corrupted state)
        fetch_data = match0 ? data_q[0][f_set][f_word] : data_q[1][f_set][f_word];
        // invalid way first (way0 preferred), otherwise the LRU way
        if (!valid_q[0][f_set])      vic = 1'b0;
        else if (!valid_q[1][f_set]) vic = 1'b1;
        else                         vic = lru_q[f_set];
        cnt_nxt = cnt_q + 1'b1;
    end

    assign busy     = (state_q != IDLE);
    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;

    // Refill FSM plus valid/LRU bookkeeping; flush overrides everything else.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            lru_q      <= '0;
            base_tag_q <= '0;
            base_set_q <= '0;
            victim_q   <= 1'b0;
            cnt_q      <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
        end else if (rdy_in) begin
            if (flush) begin
                valid_q   <= '0;
                lru_q     <= '0;
                state_q   <= IDLE;
                mem_req_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (miss) begin
                            base_tag_q          <= f_tag;
                            base_set_q          <= f_set;
                            victim_q            <= vic;
                            cnt_q               <= '0;
                            // hide the victim until the whole line is written
                            valid_q[vic][f_set] <= 1'b0;
                            mem_req_q           <= 1'b1;
                            mem_addr_q          <= {f_tag, f_set, {LINE_BITS{1'b0}}, 2'b00};
                            state_q             <= REQ;
                        end else if (fetch_hit) begin
                            // hit on way0 makes way1 the LRU one, and vice versa
                            lru_q[f_set] <= match0;
                        end
                    end
                    REQ: begin
                        if (mem_ack) begin
                            cnt_q <= cnt_nxt;
                            if (&cnt_q) begin
                                mem_req_q <= 1'b0;
                                state_q   <= FILL_DONE;
                            end else begin
                                mem_addr_q <= {base_tag_q, base_set_q, cnt_nxt, 2'b00};
                            end
                        end
                    end
                    FILL_DONE: begin
                        valid_q[victim_q][base_set_q] <= 1'b1;
                        lru_q[base_set_q]             <= ~victim_q;
                        state_q                       <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // Tag and data arrays: no reset, writes only while a refill is live.
    always_ff @(posedge clk_in) begin
        if (rdy_in && !flush) begin
            if (state_q == REQ && mem_ack)
                data_q[victim_q][base_set_q][cnt_q] <= mem_data;
            if (state_q == FILL_DONE)
                tag_q[victim_q][base_set_q] <= base_tag_q;
        end
    end

`ifdef ICACHE_PERF_COUNTERS_EN
    logic [31:0] perf_hits_q, perf_misses_q;

    // Free-running hit/miss counters; survive flush, wrap naturally.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            perf_hits_q   <= '0;
            perf_misses_q <= '0;
        end else if (rdy_in) begin
            if (fetch_hit)      perf_hits_q   <= perf_hits_q + 32'd1;
            if (miss && !flush) perf_misses_q <= perf_misses_q + 32'd1;
        end
    end

    assign perf_hits   = perf_hits_q;
    assign perf_misses = perf_misses_q;
`endif

endmodule
